// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter and one-shot sequencer in front of the data memory.
// One word access per grant; registered response with alignment/range error flag.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | waiting for a request; arbitrates and latches the winner
//   ACCESS | drives the memory for one cycle, captures read data
//   RESP   | pulses Ack/Err/Rd on the latched port for one cycle
module dmem_arbiter #(
    parameter int WORD_W = 32,
    parameter int DEPTH  = 1024
) (
    input  logic              i_clk,
    input  logic              i_rst,

    input  logic              i_Req0,
    input  logic              i_Wen0,
    input  logic [WORD_W-1:0] i_Addr0,
    input  logic [WORD_W-1:0] i_Wd0,
    output logic              o_Ack0,
    output logic              o_Err0,
    output logic [WORD_W-1:0] o_Rd0,

    input  logic              i_Req1,
    input  logic              i_Wen1,
    input  logic [WORD_W-1:0] i_Addr1,
    input  logic [WORD_W-1:0] i_Wd1,
    output logic              o_Ack1,
    output logic              o_Err1,
    output logic [WORD_W-1:0] o_Rd1,

    output logic [WORD_W-1:0] o_Mem_Addr,
    output logic [WORD_W-1:0] o_Mem_Wd,
    output logic              o_Mem_Wen,
    output logic              o_Mem_Ren,
    input  logic [WORD_W-1:0] i_Mem_Rd
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [WORD_W-1:0] MAX_ADDR = WORD_W'(DEPTH - 4);

    state_t state;
    state_t state_next;

    logic              lat_id;
    logic              lat_wen;
    logic [WORD_W-1:0] lat_addr;
    logic [WORD_W-1:0] lat_wd;
    logic              last;
    logic [WORD_W-1:0] resp_rd;
    logic              resp_err;

    logic              grant_valid;
    logic              grant_id;
    logic              addr_err;
    logic              in_access;
    logic              in_resp;

    // On a tie the port that did not win last time is granted.
    always_comb begin
        grant_valid = i_Req0 | i_Req1;
        grant_id    = 1'b0;
        if (i_Req0 && i_Req1) begin
            grant_id = ~last;
        end else if (i_Req1) begin
            grant_id = 1'b1;
        end
    end

    assign addr_err  = (lat_addr[1:0] != 2'b00) | (lat_addr > MAX_ADDR);
    assign in_access = (state == ACCESS);
    assign in_resp   = (state == RESP);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (grant_valid) begin
                    state_next = ACCESS;
                end
            end
            ACCESS:  state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            lat_id   <= 1'b0;
            lat_wen  <= 1'b0;
            lat_addr <= '0;
            lat_wd   <= '0;
            last     <= 1'b1;
            resp_rd  <= '0;
            resp_err <= 1'b0;
        end else begin
            if (state == IDLE && grant_valid) begin
                lat_id   <= grant_id;
                lat_wen  <= grant_id ? i_Wen1  : i_Wen0;
                lat_addr <= grant_id ? i_Addr1 : i_Addr0;
                lat_wd   <= grant_id ? i_Wd1   : i_Wd0;
                last     <= grant_id;
            end
            if (in_access) begin
                resp_rd  <= (lat_wen || addr_err) ? '0 : i_Mem_Rd;
                resp_err <= addr_err;
            end
        end
    end

    // Write enable is gated by reset combinationally so an aborted write never lands.
    assign o_Mem_Addr = in_access ? lat_addr : '0;
    assign o_Mem_Wd   = in_access ? lat_wd   : '0;
    assign o_Mem_Wen  = in_access & lat_wen & ~addr_err & ~i_rst;
    assign o_Mem_Ren  = in_access & ~lat_wen & ~addr_err;

    assign o_Ack0 = in_resp & ~lat_id;
    assign o_Ack1 = in_resp &  lat_id;
    assign o_Err0 = o_Ack0 & resp_err;
    assign o_Err1 = o_Ack1 & resp_err;
    assign o_Rd0  = o_Ack0 ? resp_rd : '0;
    assign o_Rd1  = o_Ack1 ? resp_rd : '0;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the byte-array data memory (async read, sync write, 32-bit word access).
- Port 0 is the core load/store path; port 1 is the debug/loader path.
- Accepts one word request at a time with round-robin fairness, drives the memory for exactly one cycle, and returns a registered response with an error flag.
- Sits between the pipeline MEM stage / debug module and the data memory.

Parameters:
WORD_W, 32, data and address width (matches `WORD_SIZE)
DEPTH, 1024, memory size in bytes (matches `DM_DEPTH); used for the range check

Ports:
i_clk  in  1  clock
i_rst  in  1  reset
i_Req0  in  1  port 0 request; held high with fields stable until o_Ack0
i_Wen0  in  1  port 0 write (1) / read (0)
i_Addr0  in  WORD_W  port 0 byte address
i_Wd0  in  WORD_W  port 0 write data
o_Ack0  out  1  port 0 one-cycle completion pulse
o_Err0  out  1  port 0 error, valid with o_Ack0
o_Rd0  out  WORD_W  port 0 read data, valid with o_Ack0
i_Req1, i_Wen1, i_Addr1, i_Wd1, o_Ack1, o_Err1, o_Rd1: same as port 0, for port 1
o_Mem_Addr  out  WORD_W  memory address
o_Mem_Wd  out  WORD_W  memory write data
o_Mem_Wen  out  1  memory write enable
o_Mem_Ren  out  1  memory read enable
i_Mem_Rd  in  WORD_W  memory read data (combinational from o_Mem_Addr)

Behaviour:
- Interface: one clock, i_clk. Reset i_rst is synchronous and active-high.
- Reset values: FSM=IDLE, o_Ack*/o_Err*=0, o_Rd*=0, o_Mem_*=0, round-robin pointer last=1 (port 0 wins the first tie).
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If any i_Req is high, pick the winner: single requester wins; if both are high, the port != last wins.
  - Latch the winner's id, Wen, Addr and Wd; set last=winner; go to ACCESS.
  - Otherwise stay in IDLE.
- Error check, computed on the latched address: err = (Addr[1:0]!=0) | (Addr > DEPTH-4).
- ACCESS (exactly 1 cycle):
  - o_Mem_Addr=latched Addr and o_Mem_Wd=latched Wd.
  - o_Mem_Wen = Wen & ~err & ~i_rst (combinational reset gate, so no write commits on a reset edge).
  - o_Mem_Ren = ~Wen & ~err.
  - Capture i_Mem_Rd into the response register (0 if write or err). Go to RESP.
- RESP (exactly 1 cycle):
  - o_AckN=1 for the latched port only; o_ErrN=err; o_RdN=captured data.
  - The other port's Ack/Err/Rd stay 0. Return to IDLE.
- Latency: request seen in IDLE at cycle N, memory access at N+1, Ack at N+2. Next request is sampled at N+3.
- Peak throughput: one access per 3 cycles.
- o_Mem_* are 0 outside ACCESS. o_Rd*/o_Err* are 0 whenever the corresponding Ack is 0.
- Requests are ignored outside IDLE. A requester must keep i_Req high and its fields stable until its Ack. Dropping i_Req before Ack has no effect on an access already latched.
- Back-to-back requests: if i_Req0 is still high in the cycle after Ack0, it is treated as a new request.
- Simultaneous requests: grants strictly alternate while both ports are held high.
- Reset mid-operation: on any i_rst edge, return to IDLE and clear all outputs and last to reset values. An in-flight write in ACCESS is not committed; an in-flight access gets no Ack.
- Data and address are passed through unmodified; there is no byte-lane or sub-word handling.

Test Plan:
- Reset, then port 0 writes Addr=0x10, Wd=0xDEADBEEF: o_Mem_Wen=1 for one cycle at N+1; Ack0 at N+2 with Err0=0. Port 0 then reads 0x10: o_Rd0=0xDEADBEEF at Ack.
- Both ports request reads continuously: first grant to port 0, then 1, 0, 1. Acks at cycles 2, 5, 8, 11 after the first request, alternating ports.
- Port 1 reads Addr=0x13 (misaligned), then Addr=DEPTH (out of range): o_Mem_Ren/Wen stay 0; Ack1 with Err1=1 and o_Rd1=0. Addr=DEPTH-4 succeeds with Err1=0.
- Port 0 write to 0x20 with i_rst asserted during ACCESS: o_Mem_Wen=0 on that edge, no Ack0; a subsequent read of 0x20 returns the old value.
- Port 1 single read while port 0 is idle: only Ack1 pulses. o_Ack0/o_Rd0 remain 0 throughout. Next tie after that goes to port 0.
